fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 141 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the upstream byte FIFO one at a time and
// sends each one as an asynchronous serial frame: start bit, eight data bits
// LSB first, then one or two stop bits. The line idles high.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_data,
   output logic        fifo_read,
   output logic        tx,
   output logic        busy,
   output logic [15:0] frame_count
);

   // The baud counter is shared by every timed state. The stop interval is
   // the longest of them, so it sets the counter width.
   localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
   localparam int CNT_W     = $clog2(STOP_CLKS);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      START,
      DATA,
      STOP
   } stateType;

   stateType         state;
   stateType         stateNext;
   logic [7:0]       shiftReg;
   logic [7:0]       shiftNext;
   logic [2:0]       bitCount;
   logic [2:0]       bitNext;
   logic [CNT_W-1:0] baudCount;
   logic [CNT_W-1:0] baudNext;
   logic [15:0]      frameNext;
   logic             txNext;

   // Both strobes are decoded from the registered state only, so no input
   // can reach them combinationally. REQ lasts exactly one cycle, which keeps
   // at most one FIFO read in flight.
   assign fifo_read = (state == REQ);
   assign busy      = (state != IDLE);

   // Next-state logic. The FIFO returns its data one cycle after the read
   // strobe, so the byte is captured only on the WAIT edge; the zeros the
   // FIFO drives in every other cycle never reach the shift register.
   // The tx line is computed from the upcoming state, so the tx register
   // changes on the same edge the state does.
   always_comb begin
      stateNext = state;
      shiftNext = shiftReg;
      bitNext   = bitCount;
      baudNext  = baudCount;
      frameNext = frame_count;
      txNext    = 1'b1;

      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               stateNext = REQ;
            end
         end
         REQ: begin
            stateNext = WAIT;
         end
         WAIT: begin
            shiftNext = fifo_data;
            baudNext  = '0;
            stateNext = START;
         end
         START: begin
            if (baudCount == BIT_LAST) begin
               baudNext  = '0;
               bitNext   = 3'd0;
               stateNext = DATA;
            end else begin
               baudNext = baudCount + CNT_W'(1);
            end
         end
         DATA: begin
            if (baudCount == BIT_LAST) begin
               baudNext  = '0;
               shiftNext = {1'b0, shiftReg[7:1]};
               if (bitCount == 3'd7) begin
                  stateNext = STOP;
               end else begin
                  bitNext = bitCount + 3'd1;
               end
            end else begin
               baudNext = baudCount + CNT_W'(1);
            end
         end
         STOP: begin
            if (baudCount == STOP_LAST) begin
               baudNext  = '0;
               frameNext = frame_count + 16'd1;
               stateNext = IDLE;
            end else begin
               baudNext = baudCount + CNT_W'(1);
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      case (stateNext)
         START:   txNext = 1'b0;
         DATA:    txNext = shiftNext[0];
         default: txNext = 1'b1;
      endcase
   end

   // State and datapath registers. Reset drops any frame in progress at
   // once, including a byte already popped, and returns the line high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         shiftReg    <= 8'h00;
         bitCount    <= 3'd0;
         baudCount   <= '0;
         frame_count <= 16'h0000;
         tx          <= 1'b1;
      end else begin
         state       <= stateNext;
         shiftReg    <= shiftNext;
         bitCount    <= bitNext;
         baudCount   <= baudNext;
         frame_count <= frameNext;
         tx          <= txNext;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a behavioural FIFO model and
// checks both the exact line waveform and the decoded bytes.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        fifo_empty;
   logic [7:0]  fifo_data;
   logic        fifo_read;
   logic        tx;
   logic        busy;
   logic [15:0] frame_count;

   logic        fifoEmpty2;
   logic [7:0]  fifoData2;
   logic        fifoRead2;
   logic        tx2;
   logic        busy2;
   logic [15:0] frameCount2;

   int checks = 0;
   int failures = 0;
   int readEmptyCount = 0;

   logic [7:0] fifoQ[$];
   logic [7:0] fifoQ2[$];
   logic [7:0] expQ[$];

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_read   (fifo_read),
      .tx          (tx),
      .busy        (busy),
      .frame_count (frame_count)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .clock       (clock),
      .reset_n     (reset_n),
      .fifo_empty  (fifoEmpty2),
      .fifo_data   (fifoData2),
      .fifo_read   (fifoRead2),
      .tx          (tx2),
      .busy        (busy2),
      .frame_count (frameCount2)
   );

   // Free-running clock, 10 ns period.
   always #5 clock = ~clock;

   // Safety net so a stuck run still ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      fifoQ.push_back(b);
      expQ.push_back(b);
      fifo_empty = 1'b0;
   endtask

   task automatic applyStimulus2(input logic [7:0] b);
      fifoQ2.push_back(b);
      fifoEmpty2 = 1'b0;
   endtask

   task automatic resetDut();
      reset_n = 1'b0;
      fifoQ.delete();
      fifoQ2.delete();
      expQ.delete();
      fifo_empty = 1'b1;
      fifoEmpty2 = 1'b1;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   // Registered-read FIFO model for the main DUT: data appears only in the
   // cycle after the read strobe and is zero otherwise.
   initial begin : fifoModel
      logic       pendingPop;
      logic [7:0] pendingByte;
      pendingPop = 1'b0;
      pendingByte = 8'h00;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            pendingPop = 1'b0;
            fifo_data = 8'h00;
         end else begin
            if (pendingPop) begin
               fifo_data = pendingByte;
               pendingPop = 1'b0;
            end else begin
               fifo_data = 8'h00;
            end
            if (fifo_read === 1'b1) begin
               if (fifoQ.size() > 0) begin
                  pendingByte = fifoQ.pop_front();
                  pendingPop = 1'b1;
               end else begin
                  readEmptyCount++;
               end
               fifo_empty = (fifoQ.size() == 0);
            end
         end
      end
   end

   // Same FIFO model for the two-stop-bit instance.
   initial begin : fifoModel2
      logic       pendingPop2;
      logic [7:0] pendingByte2;
      pendingPop2 = 1'b0;
      pendingByte2 = 8'h00;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            pendingPop2 = 1'b0;
            fifoData2 = 8'h00;
         end else begin
            if (pendingPop2) begin
               fifoData2 = pendingByte2;
               pendingPop2 = 1'b0;
            end else begin
               fifoData2 = 8'h00;
            end
            if (fifoRead2 === 1'b1) begin
               if (fifoQ2.size() > 0) begin
                  pendingByte2 = fifoQ2.pop_front();
                  pendingPop2 = 1'b1;
               end else begin
                  readEmptyCount++;
               end
               fifoEmpty2 = (fifoQ2.size() == 0);
            end
         end
      end
   end

   // Scoreboard monitor: decodes frames on tx at mid-bit and compares each
   // byte against the oldest expected byte. Reset abandons a partial frame.
   initial begin : monitor
      bit         monActive;
      int         monCnt;
      logic [7:0] monByte;
      logic [7:0] expByte;
      monActive = 1'b0;
      monCnt = 0;
      monByte = 8'h00;
      forever begin
         @(negedge clock);
         if (reset_n !== 1'b1) begin
            monActive = 1'b0;
         end else if (!monActive) begin
            if (tx === 1'b0) begin
               monActive = 1'b1;
               monCnt = 0;
               monByte = 8'h00;
            end
         end else begin
            monCnt++;
            if (monCnt >= CPB + 1 && monCnt <= 8 * CPB + 1 && ((monCnt - CPB - 1) % CPB) == 0) begin
               monByte[3'((monCnt - CPB - 1) / CPB)] = tx;
            end
            if (monCnt == 9 * CPB + 1) begin
               monActive = 1'b0;
               if (expQ.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL sbUnexpected actual=%0h required=none", monByte);
               end else begin
                  expByte = expQ.pop_front();
                  checkOutput("sbByte", 128'(monByte), 128'(expByte));
                  checkOutput("sbStop", 128'(tx), 128'(1));
               end
            end
         end
      end
   end

   // Hand-derived cycle map: frame f requests in cycle 1+f*period, starts two
   // cycles later, and frame_count steps after its last stop cycle.
   function automatic logic [127:0] expWave(input int kind, input int n, input logic [7:0] b0,
                                            input logic [7:0] b1, input int nb, input int sb);
      logic [127:0] v;
      logic         bitV;
      logic [7:0]   b;
      int           period;
      int           r;
      int           s;
      int           e;
      int           done;
      v = '0;
      period = 3 + (9 + sb) * CPB;
      for (int c = 1; c <= n; c++) begin
         bitV = (kind == 0);
         done = 0;
         for (int f = 0; f < nb; f++) begin
            r = 1 + f * period;
            s = r + 2;
            e = s + (9 + sb) * CPB - 1;
            b = (f == 0) ? b0 : b1;
            case (kind)
               0: begin
                  if (c >= s && c < s + CPB) bitV = 1'b0;
                  else if (c >= s + CPB && c < s + 9 * CPB) bitV = b[3'((c - s - CPB) / CPB)];
               end
               1: if (c == r) bitV = 1'b1;
               2: if (c >= r && c <= e) bitV = 1'b1;
               default: if (c > e) done++;
            endcase
         end
         if (kind == 3) bitV = done[0];
         v[c] = bitV;
      end
      return v;
   endfunction

   task automatic captureWave(input int n, input bit useDut2, output logic [127:0] txV,
                              output logic [127:0] rdV, output logic [127:0] byV, output logic [127:0] fcV);
      txV = '0;
      rdV = '0;
      byV = '0;
      fcV = '0;
      for (int c = 1; c <= n; c++) begin
         @(negedge clock);
         if (useDut2) begin
            txV[c] = tx2;
            rdV[c] = fifoRead2;
            byV[c] = busy2;
            fcV[c] = frameCount2[0];
         end else begin
            txV[c] = tx;
            rdV[c] = fifo_read;
            byV[c] = busy;
            fcV[c] = frame_count[0];
         end
      end
   endtask

   task automatic runFrame(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input int nb, input int sb, input bit useDut2);
      logic [127:0] txV;
      logic [127:0] rdV;
      logic [127:0] byV;
      logic [127:0] fcV;
      captureWave(n, useDut2, txV, rdV, byV, fcV);
      checkOutput({tag, "Tx"},    txV, expWave(0, n, b0, b1, nb, sb));
      checkOutput({tag, "Read"},  rdV, expWave(1, n, b0, b1, nb, sb));
      checkOutput({tag, "Busy"},  byV, expWave(2, n, b0, b1, nb, sb));
      checkOutput({tag, "CntLsb"}, fcV, expWave(3, n, b0, b1, nb, sb));
      checkOutput({tag, "Reads"}, 128'($countones(rdV)), 128'(nb));
      checkOutput({tag, "Count"}, useDut2 ? 128'(frameCount2) : 128'(frame_count), 128'(nb));
   endtask

   // Main directed sequence.
   initial begin : stimulus
      logic anyTx;
      logic anyRead;
      logic anyBusy;
      logic anyCount;

      reset_n = 1'b1;
      fifo_empty = 1'b1;
      fifo_data = 8'h00;
      fifoEmpty2 = 1'b1;
      fifoData2 = 8'h00;

      #2 reset_n = 1'b0;
      #1;
      checkOutput("resetTx",    128'(tx), 128'(1));
      checkOutput("resetBusy",  128'(busy), 128'(0));
      checkOutput("resetRead",  128'(fifo_read), 128'(0));
      checkOutput("resetCount", 128'(frame_count), 128'(0));
      checkOutput("resetTx2",   128'(tx2), 128'(1));
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      $display("[TB] single byte 0xA5");
      applyStimulus(8'hA5);
      runFrame("single", 48, 8'hA5, 8'h00, 1, 1, 1'b0);

      $display("[TB] back-to-back 0x00, 0xFF");
      resetDut();
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      runFrame("b2b", 90, 8'h00, 8'hFF, 2, 1, 1'b0);

      $display("[TB] empty FIFO for 200 cycles");
      resetDut();
      anyTx = 1'b0;
      anyRead = 1'b0;
      anyBusy = 1'b0;
      anyCount = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         if (tx !== 1'b1) anyTx = 1'b1;
         if (fifo_read !== 1'b0) anyRead = 1'b1;
         if (busy !== 1'b0) anyBusy = 1'b1;
         if (frame_count !== 16'h0000) anyCount = 1'b1;
      end
      checkOutput("emptyTxLow", 128'(anyTx), 128'(0));
      checkOutput("emptyRead",  128'(anyRead), 128'(0));
      checkOutput("emptyBusy",  128'(anyBusy), 128'(0));
      checkOutput("emptyCount", 128'(anyCount), 128'(0));

      $display("[TB] data window 0x3C");
      applyStimulus(8'h3C);
      runFrame("window", 48, 8'h3C, 8'h00, 1, 1, 1'b0);

      $display("[TB] reset during data bit 3");
      applyStimulus(8'hA5);
      repeat (20) @(negedge clock);
      checkOutput("preResetTx",   128'(tx), 128'(0));
      checkOutput("preResetBusy", 128'(busy), 128'(1));
      reset_n = 1'b0;
      #1;
      checkOutput("midResetTx",    128'(tx), 128'(1));
      checkOutput("midResetBusy",  128'(busy), 128'(0));
      checkOutput("midResetRead",  128'(fifo_read), 128'(0));
      checkOutput("midResetCount", 128'(frame_count), 128'(0));
      expQ.delete();
      applyStimulus(8'h5A);
      @(negedge clock);
      reset_n = 1'b1;
      runFrame("restart", 48, 8'h5A, 8'h00, 1, 1, 1'b0);

      $display("[TB] two stop bits 0x81");
      applyStimulus2(8'h81);
      runFrame("stop2", 50, 8'h81, 8'h00, 1, 2, 1'b1);

      repeat (4) @(negedge clock);
      checkOutput("sbDrained", 128'(expQ.size()), 128'(0));
      checkOutput("readEmpty", 128'(readEmptyCount), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
